// File: rtl/bbox_frame_ctrl.sv
// Frame-level controller for the bounding-box detector: tracks pixel position, samples the
// detector extents once per frame, validates/holds the box and publishes it with an update strobe.
module bbox_frame_ctrl #(
   parameter int ROW_CNT     = 1024,
   parameter int COL_CNT     = 768,
   parameter int HOLD_FRAMES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        data_valid,
   input  logic [10:0] det_x_min,
   input  logic [10:0] det_x_max,
   input  logic [10:0] det_y_min,
   input  logic [10:0] det_y_max,
   output logic [10:0] box_x_min,
   output logic [10:0] box_x_max,
   output logic [10:0] box_y_min,
   output logic [10:0] box_y_max,
   output logic        box_valid,
   output logic        box_update,
   output logic [15:0] frame_cnt
);

   // state  | meaning
   // IDLE   | not tracking; waits for en at the first pixel of a frame
   // SCAN   | frame in progress; leaves on the last pixel
   // SAMPLE | detector extents settle; snapshot captured on exit
   // UPDATE | snapshot evaluated; box/miss/frame counters updated
   typedef enum logic [1:0] {IDLE, SCAN, SAMPLE, UPDATE} state_t;

   localparam logic [10:0] X_LAST = 11'(ROW_CNT - 1);
   localparam logic [10:0] Y_LAST = 11'(COL_CNT - 1);
   localparam logic [8:0]  HOLD   = 9'(HOLD_FRAMES);

   state_t      state_q, state_d;
   logic [10:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
   logic [10:0] snap_x_min_q, snap_x_min_d, snap_x_max_q, snap_x_max_d;
   logic [10:0] snap_y_min_q, snap_y_min_d, snap_y_max_q, snap_y_max_d;
   logic [10:0] box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
   logic [10:0] box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
   logic        box_valid_q, box_valid_d;
   logic [7:0]  miss_cnt_q, miss_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        chg_q, chg_d;
   logic        box_update_q, box_update_d;

   logic        last_px, first_px, hit;

   always_comb begin
      state_d      = state_q;
      cnt_x_d      = cnt_x_q;
      cnt_y_d      = cnt_y_q;
      snap_x_min_d = snap_x_min_q;
      snap_x_max_d = snap_x_max_q;
      snap_y_min_d = snap_y_min_q;
      snap_y_max_d = snap_y_max_q;
      box_x_min_d  = box_x_min_q;
      box_x_max_d  = box_x_max_q;
      box_y_min_d  = box_y_min_q;
      box_y_max_d  = box_y_max_q;
      box_valid_d  = box_valid_q;
      miss_cnt_d   = miss_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      chg_d        = 1'b0;
      // the strobe trails the box change by one cycle
      box_update_d = chg_q;

      last_px  = data_valid && (cnt_x_q == X_LAST) && (cnt_y_q == Y_LAST);
      first_px = data_valid && (cnt_x_q == 11'd0) && (cnt_y_q == 11'd0);
      hit      = (snap_x_min_q <= snap_x_max_q) && (snap_y_min_q <= snap_y_max_q);

      if (data_valid) begin
         if (cnt_x_q == X_LAST) begin
            cnt_x_d = 11'd0;
            cnt_y_d = (cnt_y_q == Y_LAST) ? 11'd0 : cnt_y_q + 11'd1;
         end else begin
            cnt_x_d = cnt_x_q + 11'd1;
         end
      end

      case (state_q)
         IDLE: if (en && first_px) state_d = SCAN;
         SCAN: if (last_px) state_d = SAMPLE;
         SAMPLE: begin
            snap_x_min_d = det_x_min;
            snap_x_max_d = det_x_max;
            snap_y_min_d = det_y_min;
            snap_y_max_d = det_y_max;
            state_d      = UPDATE;
         end
         UPDATE: begin
            state_d     = en ? SCAN : IDLE;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (hit) begin
               box_x_min_d = snap_x_min_q;
               box_x_max_d = snap_x_max_q;
               box_y_min_d = snap_y_min_q;
               box_y_max_d = snap_y_max_q;
               box_valid_d = 1'b1;
               miss_cnt_d  = 8'd0;
            end else begin
               miss_cnt_d = (miss_cnt_q == 8'hFF) ? 8'hFF : miss_cnt_q + 8'd1;
               if ({1'b0, miss_cnt_d} > HOLD) begin
                  box_x_min_d = 11'd0;
                  box_x_max_d = 11'd0;
                  box_y_min_d = 11'd0;
                  box_y_max_d = 11'd0;
                  box_valid_d = 1'b0;
               end
            end
            chg_d = (box_x_min_d != box_x_min_q) || (box_x_max_d != box_x_max_q) ||
                    (box_y_min_d != box_y_min_q) || (box_y_max_d != box_y_max_q) ||
                    (box_valid_d != box_valid_q);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_x_q      <= '0;
         cnt_y_q      <= '0;
         snap_x_min_q <= '0;
         snap_x_max_q <= '0;
         snap_y_min_q <= '0;
         snap_y_max_q <= '0;
         box_x_min_q  <= '0;
         box_x_max_q  <= '0;
         box_y_min_q  <= '0;
         box_y_max_q  <= '0;
         box_valid_q  <= 1'b0;
         miss_cnt_q   <= '0;
         frame_cnt_q  <= '0;
         chg_q        <= 1'b0;
         box_update_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_x_q      <= cnt_x_d;
         cnt_y_q      <= cnt_y_d;
         snap_x_min_q <= snap_x_min_d;
         snap_x_max_q <= snap_x_max_d;
         snap_y_min_q <= snap_y_min_d;
         snap_y_max_q <= snap_y_max_d;
         box_x_min_q  <= box_x_min_d;
         box_x_max_q  <= box_x_max_d;
         box_y_min_q  <= box_y_min_d;
         box_y_max_q  <= box_y_max_d;
         box_valid_q  <= box_valid_d;
         miss_cnt_q   <= miss_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         chg_q        <= chg_d;
         box_update_q <= box_update_d;
      end
   end

   assign box_x_min  = box_x_min_q;
   assign box_x_max  = box_x_max_q;
   assign box_y_min  = box_y_min_q;
   assign box_y_max  = box_y_max_q;
   assign box_valid  = box_valid_q;
   assign box_update = box_update_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
